// File: rtl/filter_seq_pkg.sv
// Shared types and constants for the filter sequencer.
package filter_seq_pkg;

   localparam logic [2:0]  OP_LAPLACIAN = 3'd6;
   localparam logic [2:0]  OP_GRADIENT  = 3'd7;
   localparam int unsigned MAX_N        = 5;
   localparam int unsigned PIX_W        = 8;
   localparam int unsigned WIN_ELEMS    = MAX_N * MAX_N;
   localparam int unsigned WIN_BITS     = WIN_ELEMS * PIX_W;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      WRITE,
      FIN
   } state_t;

   // Window element (r,c) lives at index 5r+c.
   typedef logic [WIN_ELEMS-1:0][PIX_W-1:0] win_t;

   function automatic logic op_is_valid(input logic [2:0] op);
      return (op == OP_LAPLACIAN) || (op == OP_GRADIENT);
   endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Output-pixel (x,y) and window-element (r,c) counters with registered read address.
module window_addr_gen #(
   parameter int unsigned IMG_W  = 160,
   parameter int unsigned IMG_H  = 120,
   parameter int unsigned ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        i_n,
   input  logic              i_clear,
   input  logic              i_step,
   input  logic              i_next_pix,
   output logic [2:0]        o_r,
   output logic [2:0]        o_c,
   output logic              o_fetch_end_c,
   output logic              o_last_pix_c,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [ADDR_W-1:0] o_pix_addr
);

   localparam logic [ADDR_W-1:0] LP_W = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] LP_H = ADDR_W'(IMG_H);

   logic [ADDR_W-1:0] r_x, r_y, r_rd_addr, r_pix_addr;
   logic [2:0]        r_r, r_c;
   logic [2:0]        w_r_nxt, w_c_nxt;
   logic [ADDR_W-1:0] w_x_nxt, w_y_nxt, w_x_max, w_y_max;
   logic [ADDR_W-1:0] w_step_addr, w_pix_nxt;
   logic              w_last_c, w_last_r;

   assign w_x_max  = LP_W - ADDR_W'(i_n);
   assign w_y_max  = LP_H - ADDR_W'(i_n);
   assign w_last_c = (r_c == (i_n - 3'd1));
   assign w_last_r = (r_r == (i_n - 3'd1));

   // Next element in row-major order and next output pixel in raster order.
   always_comb begin
      w_c_nxt = r_c + 3'd1;
      w_r_nxt = r_r;
      if (w_last_c) begin
         w_c_nxt = '0;
         w_r_nxt = r_r + 3'd1;
      end
      w_x_nxt = r_x + ADDR_W'(1);
      w_y_nxt = r_y;
      if (r_x == w_x_max) begin
         w_x_nxt = '0;
         w_y_nxt = r_y + ADDR_W'(1);
      end
   end

   assign w_step_addr = (r_y + ADDR_W'(w_r_nxt)) * LP_W + r_x + ADDR_W'(w_c_nxt);
   assign w_pix_nxt   = w_y_nxt * LP_W + w_x_nxt;

   // Counter and address registers; stepping past the last element parks r at N.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x        <= '0;
         r_y        <= '0;
         r_r        <= '0;
         r_c        <= '0;
         r_rd_addr  <= '0;
         r_pix_addr <= '0;
      end else if (i_clear) begin
         r_x        <= '0;
         r_y        <= '0;
         r_r        <= '0;
         r_c        <= '0;
         r_rd_addr  <= '0;
         r_pix_addr <= '0;
      end else if (i_next_pix) begin
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_r        <= '0;
         r_c        <= '0;
         r_rd_addr  <= w_pix_nxt;
         r_pix_addr <= w_pix_nxt;
      end else if (i_step && !o_fetch_end_c) begin
         r_r <= w_r_nxt;
         r_c <= w_c_nxt;
         if (!(w_last_r && w_last_c)) begin
            r_rd_addr <= w_step_addr;
         end
      end
   end

   assign o_r           = r_r;
   assign o_c           = r_c;
   assign o_fetch_end_c = (r_r == i_n);
   assign o_last_pix_c  = (r_x == w_x_max) && (r_y == w_y_max);
   assign o_rd_addr     = r_rd_addr;
   assign o_pix_addr    = r_pix_addr;

endmodule

// File: rtl/filter_sequencer.sv
// Walks an NxN window over the image, feeds the coprocessor, writes one result per position.
module filter_sequencer
   import filter_seq_pkg::*;
#(
   parameter int unsigned IMG_W  = 160,
   parameter int unsigned IMG_H  = 120,
   parameter int unsigned ADDR_W = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [2:0]          op_code,
   input  logic [1:0]          matrix_size,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [7:0]          rd_data,
   output logic [2:0]          cop_op_code,
   output logic [1:0]          cop_matrix_size,
   output logic [WIN_BITS-1:0] cop_matrix_a,
   input  logic                cop_done,
   input  logic [7:0]          cop_result,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [7:0]          wr_data
);

   state_t            r_state, w_next_state;
   logic [2:0]        r_op, r_cop_op;
   logic [1:0]        r_size;
   logic [2:0]        w_n;
   logic              w_accept, w_reject, w_step, w_next_pix;
   logic              w_fetch_end, w_last_pix;
   logic [2:0]        w_r, w_c;
   logic [ADDR_W-1:0] w_pix_addr;
   logic [4:0]        w_cap_idx, r_cap_idx;
   logic              r_cap_v;
   win_t              r_win;
   logic              r_busy, r_done, r_err, r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;

   assign w_n       = 3'(r_size) + 3'd2;
   assign w_cap_idx = 5'(w_r) * 5'(MAX_N) + 5'(w_c);

   window_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk           (clk),
      .reset         (reset),
      .i_n           (w_n),
      .i_clear       (w_accept),
      .i_step        (w_step),
      .i_next_pix    (w_next_pix),
      .o_r           (w_r),
      .o_c           (w_c),
      .o_fetch_end_c (w_fetch_end),
      .o_last_pix_c  (w_last_pix),
      .o_rd_addr     (rd_addr),
      .o_pix_addr    (w_pix_addr)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and control strobes.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_step       = 1'b0;
      w_next_pix   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (op_is_valid(op_code)) begin
                  w_accept     = 1'b1;
                  w_next_state = FETCH;
               end else begin
                  w_reject     = 1'b1;
                  w_next_state = FIN;
               end
            end
         end
         FETCH: begin
            if (w_fetch_end) w_next_state = EXEC;
            else             w_step       = 1'b1;
         end
         EXEC: begin
            if (cop_done) w_next_state = WRITE;
         end
         WRITE: begin
            if (w_last_pix) begin
               w_next_state = FIN;
            end else begin
               w_next_state = FETCH;
               w_next_pix   = 1'b1;
            end
         end
         FIN:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Registered outputs, latched request and window capture (one cycle behind the read).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_op      <= '0;
         r_size    <= '0;
         r_cop_op  <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_cap_v   <= 1'b0;
         r_cap_idx <= '0;
         r_win     <= '0;
      end else begin
         r_done   <= (w_next_state == FIN);
         r_wr_en  <= (w_next_state == WRITE);
         r_cop_op <= (w_next_state == EXEC) ? r_op : 3'd0;
         r_cap_v  <= (r_state == FETCH) && !w_fetch_end;
         r_cap_idx <= w_cap_idx;

         if (w_accept) begin
            r_busy <= 1'b1;
            r_err  <= 1'b0;
            r_op   <= op_code;
            r_size <= matrix_size;
         end else if (w_next_state == FIN) begin
            r_busy <= 1'b0;
         end
         if (w_reject) r_err <= 1'b1;

         if ((r_state == EXEC) && cop_done) begin
            r_wr_data <= cop_result;
            r_wr_addr <= w_pix_addr;
         end

         if (w_accept || w_next_pix) r_win            <= '0;
         else if (r_cap_v)           r_win[r_cap_idx] <= rd_data;
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign err             = r_err;
   assign cop_op_code     = r_cop_op;
   assign cop_matrix_size = r_size;
   assign cop_matrix_a    = r_win;
   assign wr_en           = r_wr_en;
   assign wr_addr         = r_wr_addr;
   assign wr_data         = r_wr_data;

endmodule

// File: doc/filter_sequencer.md
FILTER_SEQUENCER -- requirements
Module: filter_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 160, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 120, image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 15, pixel address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-004 SHALL have one clock; reset is asynchronous and active-high. Ports: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-005 SHALL have ports:
  start  in  1  one-cycle request to filter the whole image.
  op_code  in  3  6 = Laplacian, 7 = gradient; sampled on start.
  matrix_size  in  2  window N = matrix_size+2 (2x2..5x5); sampled on start.
  busy  out  1  high from accepted start until done.
  done  out  1  one-cycle completion pulse.
  err  out  1  valid with done; 1 = invalid op_code, no writes made.
  rd_addr  out  ADDR_W  source image read address.
  rd_data  in  8  pixel at rd_addr of the previous cycle (1-cycle latency).
  cop_op_code  out  3  coprocessor op code.
  cop_matrix_size  out  2  coprocessor size.
  cop_matrix_a  out  200  window, element (r,c) at bits [8*(5r+c)+7 : 8*(5r+c)].
  cop_done  in  1  coprocessor process_Done.
  cop_result  in  8  coprocessor result byte (result_final[7:0]).
  wr_en  out  1  result write strobe.
  wr_addr  out  ADDR_W  result address.
  wr_data  out  8  result pixel.

Function
REQ-006 SHALL use states IDLE, FETCH, EXEC, WRITE, FIN.
REQ-007 IDLE: start=1 with op_code 6 or 7 SHALL latch op_code/matrix_size, set x=y=0, clear window buffer, go to FETCH, assert busy next cycle.
REQ-008 IDLE: start=1 with any other op_code SHALL go to FIN with err=1; no rd or wr activity.
REQ-009 start while busy SHALL be ignored; latched op_code/matrix_size SHALL NOT change mid-run.
REQ-010 FETCH SHALL issue rd_addr = (y+r)*IMG_W + (x+c) for r,c in 0..N-1, row-major, one per cycle, and capture rd_data one cycle later into element (r,c); FETCH lasts N*N+1 cycles.
REQ-011 Window elements with r>=N or c>=N SHALL be zero.
REQ-012 cop_op_code SHALL equal the latched op only in EXEC, otherwise 0; cop_matrix_size and cop_matrix_a SHALL be held stable from FETCH end through EXEC.
REQ-013 EXEC SHALL wait, without timeout, until cop_done=1, then register cop_result and go to WRITE.
REQ-014 WRITE SHALL assert wr_en for exactly one cycle with wr_addr = y*IMG_W + x and the registered result.
REQ-015 After WRITE: x increments; at x = IMG_W-N, x wraps to 0 and y increments; after x = IMG_W-N, y = IMG_H-N go to FIN, else FETCH (window buffer cleared).
REQ-016 Output coordinates SHALL cover x in 0..IMG_W-N, y in 0..IMG_H-N, in raster order; other result addresses are never written.
REQ-017 FIN SHALL pulse done for one cycle, drop busy in the same cycle, return to IDLE; err SHALL hold until the next accepted start.
REQ-018 Address arithmetic SHALL be ADDR_W-bit unsigned with no overflow for legal parameters.

Reset
REQ-019 reset SHALL force state IDLE and busy, done, err, wr_en, rd_addr, wr_addr, wr_data, cop_op_code, cop_matrix_size, cop_matrix_a, counters to 0, asynchronously, including mid-run; no write SHALL occur after reset assertion.

Structure
REQ-020 Package filter_seq_pkg SHALL hold the state enum, OP_LAPLACIAN=3'd6, OP_GRADIENT=3'd7, MAX_N=5.
REQ-021 Window address/counter generation (r,c,x,y) SHALL be sub-module window_addr_gen.

Verification (IMG_W=IMG_H=4, memory preloaded pixel=address)
REQ-022 op 7, size 1 (3x3), cop_done tied 1: exactly 4 writes at addr 0,1,4,5 in order, 12 cycles per pixel, then one done pulse with err=0.
REQ-023 op 6, size 3 (5x5) on 4x4: no legal window is impossible -> set IMG_W=IMG_H=5, expect one write at addr 0, cop_matrix_a bytes 0..24 = pixels 0..24.
REQ-024 size 0 (2x2): window bytes 0,1,5,6 = pixels at x,x+1,x+4,x+5, all others zero; 9 writes.
REQ-025 op_code 3 with start: done+err next state, zero wr_en/rd activity, busy never 1 beyond FIN.
REQ-026 cop_done held 0 for 20 cycles in EXEC: no write, cop_op_code stays 7; reset asserted then: all outputs 0 immediately, no further writes, start afterwards runs normally.
